kbd_source_arbiter: RTL and testbench

- Sits between the PS/2 byte receiver and the PS/2-to-C64 keyboard-matrix decoder.
- Merges two scan-code sources onto the decoder's single data/data_rdy byte strobe:
  - live PS/2 bytes;
  - an injector port that synthesises complete key taps (make, hold, break, gap) for auto-typing and loaders.
- The decoder keeps E0/F0 prefix state between bytes, so the arbiter never interleaves a multi-byte sequence from one source with bytes from the other.

---
 rtl/kbd_source_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_kbd_source_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_source_arbiter.sv
// Merges buffered PS/2 bytes and synthesised key taps onto the decoder's byte strobe without splitting prefix sequences.
// Two-cycle ps2_rdy/handshake to data_rdy; no backpressure, so a PS/2 byte that finds the buffer full is dropped and flagged.
module kbd_source_arbiter #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 20,
  parameter int HOLD_CYCLES = 40000,
  parameter int GAP_CYCLES  = 40000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_data,
  input  logic       ps2_rdy,
  input  logic [7:0] inj_code,
  input  logic       inj_ext,
  input  logic       inj_valid,
  output logic       inj_ready,
  output logic       inj_busy,
  output logic [7:0] data,
  output logic       data_rdy,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;

  typedef enum logic [2:0] {I_IDLE, I_MAKE, I_HOLD, I_BREAK, I_GAP} inj_state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  inj_state_t     r_state;
  logic [7:0]     r_code;
  logic           r_ext;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]     r_idx;
  logic           r_burst;
  logic           r_lock;
  logic [7:0]     r_data;
  logic           r_data_rdy;
  logic           r_overflow;
  logic           r_inj_ready;
  logic           r_inj_busy;

  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_head;
  logic       w_inj_phase;
  logic       w_inj_go;
  logic [1:0] w_len_m1;
  logic [1:0] w_rem;
  logic       w_last;
  logic [7:0] w_inj_byte;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_push  = ps2_rdy && !w_full;
  assign w_head  = r_mem[r_rd_ptr];

  // An open injector burst always wins; a new burst may only start on an empty, unlocked PS/2 path.
  assign w_inj_phase = (r_state == I_MAKE) || (r_state == I_BREAK);
  assign w_inj_go    = r_burst || (w_inj_phase && !r_lock && w_empty);
  assign w_pop       = !w_inj_go && !w_empty;

  // Burst bytes are picked by distance from the final code byte: [E0] [F0] code.
  assign w_len_m1 = ((r_state == I_BREAK) ? 2'd1 : 2'd0) + {1'b0, r_ext};
  assign w_rem    = w_len_m1 - r_idx;
  assign w_last   = (w_rem == 2'd0);

  always_comb begin
    w_inj_byte = r_code;
    if (w_rem == 2'd2)
      w_inj_byte = B_E0;
    else if (w_rem == 2'd1)
      w_inj_byte = (r_state == I_BREAK) ? B_F0 : B_E0;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= ps2_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= '0;
      r_data_rdy <= 1'b0;
      r_lock     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_data_rdy <= w_inj_go || w_pop;
      if (w_inj_go) begin
        r_data <= w_inj_byte;
      end else if (w_pop) begin
        r_data <= w_head;
        r_lock <= (w_head == B_E0) || (w_head == B_F0);
      end
      // Fullness is judged before any same-cycle pop.
      if (ps2_rdy && w_full)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= I_IDLE;
      r_code      <= '0;
      r_ext       <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_burst     <= 1'b0;
      r_inj_ready <= 1'b0;
      r_inj_busy  <= 1'b0;
    end else begin
      case (r_state)
        I_IDLE: begin
          r_inj_ready <= 1'b1;
          r_inj_busy  <= 1'b0;
          if (inj_valid && r_inj_ready) begin
            r_code      <= inj_code;
            r_ext       <= inj_ext;
            r_idx       <= '0;
            r_inj_ready <= 1'b0;
            r_inj_busy  <= 1'b1;
            r_state     <= I_MAKE;
          end
        end
        I_MAKE, I_BREAK: begin
          if (w_inj_go) begin
            if (w_last) begin
              r_burst <= 1'b0;
              r_idx   <= '0;
              r_cnt   <= (r_state == I_MAKE) ? HOLD_LD : GAP_LD;
              r_state <= (r_state == I_MAKE) ? I_HOLD : I_GAP;
            end else begin
              r_burst <= 1'b1;
              r_idx   <= r_idx + 2'd1;
            end
          end
        end
        I_HOLD, I_GAP: begin
          if (r_cnt == '0) begin
            r_state     <= (r_state == I_HOLD) ? I_BREAK : I_IDLE;
            r_inj_ready <= (r_state == I_GAP);
            r_inj_busy  <= (r_state == I_HOLD);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= I_IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign data_rdy  = r_data_rdy;
  assign overflow  = r_overflow;
  assign inj_ready = r_inj_ready;
  assign inj_busy  = r_inj_busy;
endmodule

// File: tb/tb_kbd_source_arbiter.sv
// Bench for kbd_source_arbiter: directed tap/PS2 scenarios plus random traffic, all cycles compared against a
// queue-and-deadline reference model; a second depth-2 instance exposes the drop/overflow path.
module tb_kbd_source_arbiter;
  localparam int HOLD  = 4;
  localparam int GAP   = 3;
  localparam int DEPTH = 4;
  localparam int MAXC  = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ps2_rdy, inj_ext, inj_valid;
  logic [7:0] ps2_data, inj_code;
  logic       inj_ready, inj_busy, data_rdy, overflow;
  logic [7:0] data;
  logic       s_ready, s_busy, s_rdy, s_ovf;
  logic [7:0] s_data;

  kbd_source_arbiter #(.FIFO_DEPTH(DEPTH), .CNT_W(20), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .reset(reset), .ps2_data(ps2_data), .ps2_rdy(ps2_rdy),
    .inj_code(inj_code), .inj_ext(inj_ext), .inj_valid(inj_valid),
    .inj_ready(inj_ready), .inj_busy(inj_busy), .data(data), .data_rdy(data_rdy), .overflow(overflow)
  );

  kbd_source_arbiter #(.FIFO_DEPTH(2), .CNT_W(20), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) u_dut_d2 (
    .clk(clk), .reset(reset), .ps2_data(ps2_data), .ps2_rdy(ps2_rdy),
    .inj_code(inj_code), .inj_ext(inj_ext), .inj_valid(inj_valid),
    .inj_ready(s_ready), .inj_busy(s_busy), .data(s_data), .data_rdy(s_rdy), .overflow(s_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: PS/2 queue, pending/open burst byte queue, and phase deadlines in absolute cycles.
  typedef enum int {P_IDLE, P_MAKE, P_HOLD, P_BREAK, P_GAP} ph_t;
  logic [7:0] m_q[$];
  logic [7:0] m_bq[$];
  bit         m_lock, m_bon, m_ext;
  ph_t        m_ph;
  int         m_wake;
  logic [7:0] m_code;
  bit         e_rdy, e_ready, e_busy, e_ovf;
  logic [7:0] e_data;

  int         cyc_n = 0;
  logic [8:0] lg [MAXC];
  int         rise_at = -1;
  bit         pr_ready = 1'b0;
  logic [7:0] q2[$];

  task automatic fill_burst(input bit brk);
    m_bq.delete();
    if (m_ext) m_bq.push_back(8'hE0);
    if (brk)   m_bq.push_back(8'hF0);
    m_bq.push_back(m_code);
  endtask

  task automatic model_step(input bit rst, input bit prdy, input logic [7:0] pd,
                            input bit iv, input logic [7:0] ic, input bit ie);
    int c;
    int sz;
    bit em;
    bit rdy_now;
    logic [7:0] eb;
    c = cyc_n;
    if (rst) begin
      m_q.delete(); m_bq.delete();
      m_lock = 0; m_bon = 0; m_ph = P_IDLE;
      e_rdy = 0; e_data = 8'h00; e_ovf = 0; e_ready = 0; e_busy = 0;
      return;
    end
    rdy_now = e_ready;
    sz = m_q.size();
    em = 0;
    eb = 8'h00;
    if (m_bon) begin
      eb = m_bq.pop_front(); em = 1;
    end else if (sz > 0) begin
      eb = m_q.pop_front(); em = 1;
      m_lock = (eb == 8'hE0) || (eb == 8'hF0);
    end else if (!m_lock && (m_ph == P_MAKE || m_ph == P_BREAK)) begin
      m_bon = 1; eb = m_bq.pop_front(); em = 1;
    end
    if (m_bon && m_bq.size() == 0) begin
      m_bon = 0;
      if (m_ph == P_MAKE) begin m_ph = P_HOLD; m_wake = c + HOLD + 1; end
      else begin m_ph = P_GAP; m_wake = c + GAP + 1; end
    end
    if (prdy) begin
      if (sz < DEPTH) m_q.push_back(pd);
      else e_ovf = 1;
    end
    if (iv && rdy_now) begin
      m_code = ic; m_ext = ie; m_ph = P_MAKE; fill_burst(0);
    end
    if (m_ph == P_HOLD && c + 1 >= m_wake) begin m_ph = P_BREAK; fill_burst(1); end
    if (m_ph == P_GAP && c + 1 >= m_wake) m_ph = P_IDLE;
    e_rdy = em;
    if (em) e_data = eb;
    e_busy  = (m_ph != P_IDLE);
    e_ready = (m_ph == P_IDLE);
  endtask

  task automatic cyc(input bit rst, input bit prdy, input logic [7:0] pd,
                     input bit iv, input logic [7:0] ic, input bit ie);
    reset = rst; ps2_rdy = prdy; ps2_data = pd; inj_valid = iv; inj_code = ic; inj_ext = ie;
    model_step(rst, prdy, pd, iv, ic, ie);
    @(posedge clk);
    #1;
    cyc_n++;
    chk("data_rdy",  16'(data_rdy),  16'(e_rdy));
    chk("data",      16'(data),      16'(e_data));
    chk("inj_ready", 16'(inj_ready), 16'(e_ready));
    chk("inj_busy",  16'(inj_busy),  16'(e_busy));
    chk("overflow",  16'(overflow),  16'(e_ovf));
    if (cyc_n < MAXC) lg[cyc_n] = {data_rdy, data};
    if (inj_ready && !pr_ready) rise_at = cyc_n;
    pr_ready = inj_ready;
    if (s_rdy) q2.push_back(s_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic ps2(input logic [7:0] b);
    cyc(0, 1, b, 0, 8'h00, 0);
  endtask

  task automatic tap(input logic [7:0] code, input bit ext);
    cyc(0, 0, 8'h00, 1, code, ext);
  endtask

  logic [7:0] tbl [6] = '{8'hE0, 8'hF0, 8'h1C, 8'h29, 8'h6C, 8'h75};
  logic [7:0] exp2 [8] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h11, 8'h22, 8'h55};

  initial begin
    int h, p, n;
    reset = 1; ps2_rdy = 0; ps2_data = 0; inj_valid = 0; inj_code = 0; inj_ext = 0;
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    idle(2);

    // PS/2 only
    p = cyc_n;
    ps2(8'h1C); idle(9); ps2(8'hF0); idle(9); ps2(8'h1C); idle(9);
    chk("ps2_first",  16'(lg[p + 2]),  16'h011C);
    chk("ps2_f0",     16'(lg[p + 12]), 16'h01F0);
    chk("ps2_second", 16'(lg[p + 22]), 16'h011C);

    // Plain tap
    h = cyc_n;
    tap(8'h29, 0); idle(14);
    chk("tap_make",     16'(lg[h + 2]), 16'h0129);
    chk("tap_no_early", 16'(lg[h + 6][8]), 16'h0000);
    chk("tap_f0",       16'(lg[h + 7]), 16'h01F0);
    chk("tap_break",    16'(lg[h + 8]), 16'h0129);
    chk("tap_ready_back", 16'(rise_at - h), 16'd11);

    // Extended tap
    h = cyc_n;
    tap(8'h75, 1); idle(16);
    chk("ext_make_e0", 16'(lg[h + 2]),  16'h01E0);
    chk("ext_make",    16'(lg[h + 3]),  16'h0175);
    chk("ext_brk_e0",  16'(lg[h + 8]),  16'h01E0);
    chk("ext_brk_f0",  16'(lg[h + 9]),  16'h01F0);
    chk("ext_brk",     16'(lg[h + 10]), 16'h0175);

    // Interleave protection
    p = cyc_n;
    ps2(8'hE0); idle(1); tap(8'h29, 0); idle(2); ps2(8'h6C); idle(20);
    n = 0;
    for (int i = p + 3; i <= p + 6; i++) if (lg[i][8]) n++;
    chk("lock_e0",   16'(lg[p + 2]), 16'h01E0);
    chk("lock_wait", 16'(n), 16'd0);
    chk("lock_6c",   16'(lg[p + 7]), 16'h016C);
    chk("lock_29",   16'(lg[p + 8]), 16'h0129);

    // Burst atomicity
    h = cyc_n;
    tap(8'h29, 0); idle(5); ps2(8'h16); idle(12);
    chk("atom_f0", 16'(lg[h + 7]), 16'h01F0);
    chk("atom_29", 16'(lg[h + 8]), 16'h0129);
    chk("atom_16", 16'(lg[h + 9]), 16'h0116);

    // Overflow: back-to-back pushes during a break burst
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    q2.delete();
    idle(1);
    tap(8'h75, 1); idle(6);
    ps2(8'h11); ps2(8'h22); ps2(8'h33); ps2(8'h44); ps2(8'h55);
    idle(12);
    chk("d2_count", 16'(q2.size()), 16'd8);
    for (int i = 0; i < 8; i++)
      chk("d2_seq", (i < q2.size()) ? 16'(q2[i]) : 16'hFFFF, 16'(exp2[i]));
    chk("d2_overflow", 16'(s_ovf),   16'd1);
    chk("d2_idle",     16'(s_busy),  16'd0);
    chk("d2_ready",    16'(s_ready), 16'd1);
    chk("d4_no_ovf",   16'(overflow), 16'd0);

    // Reset during hold
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    chk("d2_ovf_cleared", 16'(s_ovf), 16'd0);
    idle(1);
    h = cyc_n;
    tap(8'h29, 0); idle(2);
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    idle(16);
    n = 0;
    for (int i = h + 4; i < h + 20; i++) if (lg[i][8]) n++;
    chk("rst_make_seen", 16'(lg[h + 2]), 16'h0129);
    chk("rst_no_break",  16'(n), 16'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0, tbl[$urandom_range(0, 5)],
          $urandom_range(0, 3) == 0, tbl[$urandom_range(2, 5)], 1'($urandom_range(0, 1)));
    end
    idle(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
